// File: rtl/aes_core_arb.sv
`default_nettype none
// ============================================================================
// Module      : aes_core_arb
// Description : Round-robin arbiter that shares one AES core between two
//               requesters. Latches the winning command, runs key expansion
//               only when the cached expanded key differs, runs one block
//               operation and returns the result to the owning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_core_arb #(
    parameter bit KEY_CACHE_EN = 1'b1
) (
    input  logic         aes_clk,
    input  logic         aes_rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [255:0] key0,
    input  logic [255:0] key1,
    input  logic         keylen0,
    input  logic         keylen1,
    input  logic         encdec0,
    input  logic         encdec1,
    input  logic [127:0] block0,
    input  logic [127:0] block1,
    output logic         grant0,
    output logic         grant1,
    output logic         done0,
    output logic         done1,
    output logic [127:0] result0,
    output logic [127:0] result1,
    output logic         core_init,
    output logic         core_next,
    output logic         core_encdec,
    output logic         core_keylen,
    output logic [255:0] core_key,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic [127:0] core_result,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KEY_INIT  = 3'd1,
        S_KEY_WAIT  = 3'd2,
        S_BLK_START = 3'd3,
        S_BLK_WAIT  = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t         r_state;
    logic           r_last_winner;
    logic           r_owner;
    logic           r_wait_first;
    logic           r_key_valid;
    logic [255:0]   r_cache_key;
    logic           r_cache_keylen;
    logic           r_core_init;
    logic           r_core_next;
    logic           r_done0;
    logic           r_done1;
    logic [127:0]   r_result0;
    logic [127:0]   r_result1;
    logic [255:0]   r_core_key;
    logic           r_core_keylen;
    logic           r_core_encdec;
    logic [127:0]   r_core_block;

    logic           w_any_req;
    logic           w_grant_ok;
    logic           w_winner;
    logic [255:0]   w_sel_key;
    logic           w_sel_keylen;
    logic           w_sel_encdec;
    logic [127:0]   w_sel_block;
    logic           w_cache_hit;

    // Grant is decided combinationally in IDLE so it pulses in the cycle the
    // command is latched; on a tie the requester that did not win last time
    // is chosen.
    assign w_any_req    = req0 | req1;
    assign w_grant_ok   = (r_state == S_IDLE) && !aes_rst && core_ready && w_any_req;
    assign w_winner     = (req0 && req1) ? ~r_last_winner : req1;
    assign w_sel_key    = w_winner ? key1    : key0;
    assign w_sel_keylen = w_winner ? keylen1 : keylen0;
    assign w_sel_encdec = w_winner ? encdec1 : encdec0;
    assign w_sel_block  = w_winner ? block1  : block0;
    assign w_cache_hit  = KEY_CACHE_EN && r_key_valid &&
                          (w_sel_key == r_cache_key) &&
                          (w_sel_keylen == r_cache_keylen);

    assign grant0      = w_grant_ok && !w_winner;
    assign grant1      = w_grant_ok &&  w_winner;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign result0     = r_result0;
    assign result1     = r_result1;
    assign core_init   = r_core_init;
    assign core_next   = r_core_next;
    assign core_key    = r_core_key;
    assign core_keylen = r_core_keylen;
    assign core_encdec = r_core_encdec;
    assign core_block  = r_core_block;
    assign busy        = (r_state != S_IDLE);

    // Sequencer: latch command, optional key expansion, one block op, done.
    always_ff @(posedge aes_clk) begin
        if (aes_rst) begin
            r_state        <= S_IDLE;
            r_last_winner  <= 1'b1;
            r_owner        <= 1'b0;
            r_wait_first   <= 1'b0;
            r_key_valid    <= 1'b0;
            r_cache_key    <= '0;
            r_cache_keylen <= 1'b0;
            r_core_init    <= 1'b0;
            r_core_next    <= 1'b0;
            r_done0        <= 1'b0;
            r_done1        <= 1'b0;
            r_result0      <= '0;
            r_result1      <= '0;
            r_core_key     <= '0;
            r_core_keylen  <= 1'b0;
            r_core_encdec  <= 1'b0;
            r_core_block   <= '0;
        end else begin
            r_core_init <= 1'b0;
            r_core_next <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ok) begin
                        r_owner       <= w_winner;
                        r_last_winner <= w_winner;
                        r_core_key    <= w_sel_key;
                        r_core_keylen <= w_sel_keylen;
                        r_core_encdec <= w_sel_encdec;
                        r_core_block  <= w_sel_block;
                        if (w_cache_hit) begin
                            r_state     <= S_BLK_START;
                            r_core_next <= 1'b1;
                        end else begin
                            r_state     <= S_KEY_INIT;
                            r_core_init <= 1'b1;
                        end
                    end
                end
                S_KEY_INIT: begin
                    r_state      <= S_KEY_WAIT;
                    r_wait_first <= 1'b1;
                end
                S_KEY_WAIT: begin
                    // The core may still show the stale ready in the first
                    // cycle after a command, so that cycle is skipped.
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (core_ready) begin
                        r_cache_key    <= r_core_key;
                        r_cache_keylen <= r_core_keylen;
                        r_key_valid    <= 1'b1;
                        r_state        <= S_BLK_START;
                        r_core_next    <= 1'b1;
                    end
                end
                S_BLK_START: begin
                    r_state      <= S_BLK_WAIT;
                    r_wait_first <= 1'b1;
                end
                S_BLK_WAIT: begin
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (core_ready) begin
                        r_state <= S_DONE;
                        if (r_owner) begin
                            r_result1 <= core_result;
                            r_done1   <= 1'b1;
                        end else begin
                            r_result0 <= core_result;
                            r_done0   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_core_arb
// Description : Self-checking bench for aes_core_arb with a behavioural AES
//               core stub and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_core_arb;

    localparam int KL = 3;   // cycles the core stays not-ready after init
    localparam int BL = 4;   // cycles the core stays not-ready after next

    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         aes_clk = 1'b0;
    logic         aes_rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [255:0] key0 = '0, key1 = '0;
    logic         keylen0 = 1'b0, keylen1 = 1'b0;
    logic         encdec0 = 1'b0, encdec1 = 1'b0;
    logic [127:0] block0 = '0, block1 = '0;
    logic         grant0, grant1, done0, done1;
    logic [127:0] result0, result1;
    logic         core_init, core_next, core_encdec, core_keylen;
    logic [255:0] core_key;
    logic [127:0] core_block;
    logic         core_ready;
    logic [127:0] core_result;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    aes_core_arb #(.KEY_CACHE_EN(1'b1)) dut (
        .aes_clk(aes_clk), .aes_rst(aes_rst),
        .req0(req0), .req1(req1), .key0(key0), .key1(key1),
        .keylen0(keylen0), .keylen1(keylen1), .encdec0(encdec0), .encdec1(encdec1),
        .block0(block0), .block1(block1), .grant0(grant0), .grant1(grant1),
        .done0(done0), .done1(done1), .result0(result0), .result1(result1),
        .core_init(core_init), .core_next(core_next), .core_encdec(core_encdec),
        .core_keylen(core_keylen), .core_key(core_key), .core_block(core_block),
        .core_ready(core_ready), .core_result(core_result), .busy(busy)
    );

    always #5 aes_clk = ~aes_clk;
    always @(posedge aes_clk) cyc <= cyc + 1;

    // Known FIPS-197 vectors; any other combination maps to a simple mix so
    // that a wrong key, block or direction still changes the answer.
    function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic kl,
                                             input logic ed, input logic [127:0] b);
        if (kl && k == K256 && ed && b == PT)                   return CT256;
        if (kl && k == K256 && !ed && b == CT256)               return PT;
        if (!kl && k[255:128] == K128[255:128] && ed && b == PT)      return CT128;
        if (!kl && k[255:128] == K128[255:128] && !ed && b == CT128)  return PT;
        return b ^ k[255:128] ^ (kl ? k[127:0] : 128'h0) ^ {127'h0, ed};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- AES core stub ----------------
    logic [255:0] st_key = '0;
    logic         st_kl = 1'b0;
    logic [127:0] st_pend = '0, st_res = '0;
    int           st_cnt = 0;
    logic         st_ready = 1'b1;
    logic         stall = 1'b0;

    always @(posedge aes_clk) begin
        if (aes_rst) begin
            st_ready <= 1'b1;
            st_cnt   <= 0;
            st_res   <= '0;
            st_key   <= '0;
            st_kl    <= 1'b0;
        end else if (core_init) begin
            st_key   <= core_key;
            st_kl    <= core_keylen;
            st_cnt   <= KL;
            st_ready <= 1'b0;
        end else if (core_next) begin
            st_pend  <= aes_ref(st_key, st_kl, core_encdec, core_block);
            st_cnt   <= BL;
            st_ready <= 1'b0;
        end else if (st_cnt == 1) begin
            st_cnt   <= 0;
            st_ready <= 1'b1;
            st_res   <= st_pend;
        end else if (st_cnt > 1) begin
            st_cnt   <= st_cnt - 1;
        end
    end
    assign core_ready  = st_ready & ~stall;
    assign core_result = st_res;

    // ---------------- pulse counters ----------------
    int n_init = 0, n_grant = 0, n_done0 = 0;
    always @(negedge aes_clk) begin
        if (core_init)        n_init  <= n_init + 1;
        if (grant0 || grant1) n_grant <= n_grant + 1;
        if (done0)            n_done0 <= n_done0 + 1;
    end

    // ---------------- transaction-level reference model + compare ----------------
    bit           m_active = 0, m_last = 1, m_cvalid = 0, m_hit = 0, m_own = 0;
    logic [255:0] m_ckey = '0, m_key = '0;
    logic         m_ckl = 0, m_kl = 0, m_ed = 0;
    logic [127:0] m_blk = '0, m_res = '0, m_res0 = '0, m_res1 = '0;
    int           m_g = 0, m_d = 0;

    always @(negedge aes_clk) begin
        logic [6:0] ectl;   // grant0 grant1 done0 done1 init next busy
        bit go_busy, go_idle, w;
        go_busy = 0;
        go_idle = 0;
        if (aes_rst) begin
            chk("rst_grant", {grant0, grant1}, 2'b00);
            m_active = 0; m_last = 1; m_cvalid = 0;
            m_res0 = '0; m_res1 = '0;
        end else begin
            ectl = '0;
            if (m_active) begin
                ectl[0] = 1'b1;
                if (!m_hit && cyc == m_g + 1) ectl[2] = 1'b1;
                if (cyc == (m_hit ? m_g + 1 : m_g + KL + 3)) ectl[1] = 1'b1;
                if (cyc == m_d) begin
                    go_idle = 1;
                    if (m_own) begin ectl[3] = 1'b1; m_res1 = m_res; end
                    else       begin ectl[4] = 1'b1; m_res0 = m_res; end
                end
                chk("core_key", core_key, m_key);
                chk("core_cmd", {core_keylen, core_encdec, core_block}, {m_kl, m_ed, m_blk});
            end else if ((req0 || req1) && core_ready) begin
                w = (req0 && req1) ? !m_last : req1;
                if (w) ectl[5] = 1'b1; else ectl[6] = 1'b1;
                m_own = w;
                m_key = w ? key1 : key0;
                m_kl  = w ? keylen1 : keylen0;
                m_ed  = w ? encdec1 : encdec0;
                m_blk = w ? block1 : block0;
                m_hit = m_cvalid && (m_key == m_ckey) && (m_kl == m_ckl);
                m_g   = cyc;
                m_d   = cyc + BL + 3 + (m_hit ? 0 : KL + 2);
                m_res = aes_ref(m_key, m_kl, m_ed, m_blk);
                m_last = w;
                if (!m_hit) begin m_cvalid = 1; m_ckey = m_key; m_ckl = m_kl; end
                go_busy = 1;
            end
            chk("ctrl", {grant0, grant1, done0, done1, core_init, core_next, busy}, ectl);
            chk("result0", result0, m_res0);
            chk("result1", result1, m_res1);
            if (go_idle) m_active = 0;
            if (go_busy) m_active = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic bit sig(input int which);
        case (which)
            0: return grant0;
            1: return grant1;
            2: return done0;
            3: return done1;
            4: return grant0 | grant1;
            5: return core_next;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string nm, output int c);
        bit got = 0;
        c = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge aes_clk);
            if (sig(which)) begin got = 1; c = cyc; end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout waiting, got none expected event", nm);
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctl"}, {grant0, grant1, done0, done1, core_init, core_next, busy,
                           core_keylen, core_encdec}, '0);
        chk({nm, "_res"}, {result0, result1}, '0);
        chk({nm, "_key"}, core_key, '0);
        chk({nm, "_blk"}, core_block, '0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int g, d, i0, g0, d0, ord, who;
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, d, i0, g0, d0, ord, who;
        repeat (3) @(posedge aes_clk);
        #1 aes_rst = 1'b0;
        @(negedge aes_clk);
        check_all_zero("reset");

        // Single 256-bit encrypt, cold cache
        @(posedge aes_clk); #1;
        key0 = K256; keylen0 = 1'b1; encdec0 = 1'b1; block0 = PT; req0 = 1'b1;
        wait_sig(0, "t1_grant", g);
        i0 = n_init;
        @(posedge aes_clk); #1 req0 = 1'b0;
        wait_sig(2, "t1_done", d);
        chk("t1_result", result0, CT256);
        chk("t1_latency", d - g, 12);
        chk("t1_init", n_init - i0, 1);

        // Same key, new block (decrypt): cache hit, no key expansion
        @(posedge aes_clk); #1;
        block0 = CT256; encdec0 = 1'b0; req0 = 1'b1;
        wait_sig(0, "t2_grant", g);
        i0 = n_init;
        @(posedge aes_clk); #1 req0 = 1'b0;
        wait_sig(2, "t2_done", d);
        chk("t2_result", result0, PT);
        chk("t2_latency", d - g, 7);
        chk("t2_init", n_init - i0, 0);

        // 128-bit key on requester 1; inputs scrambled after the grant
        @(posedge aes_clk); #1;
        key1 = K128; keylen1 = 1'b0; encdec1 = 1'b1; block1 = PT; req1 = 1'b1;
        wait_sig(1, "t3_grant", g);
        i0 = n_init;
        @(posedge aes_clk); #1;
        req1 = 1'b0; key1 = {8{32'hdeadbeef}}; block1 = 128'h5a5a; encdec1 = 1'b0; keylen1 = 1'b1;
        wait_sig(3, "t3_done", d);
        chk("t3_result", result1, CT128);
        chk("t3_latency", d - g, 12);
        chk("t3_init", n_init - i0, 1);

        // Contention: both held, grants must alternate starting with req0
        @(posedge aes_clk); #1;
        key1 = K128; keylen1 = 1'b0; encdec1 = 1'b1; block1 = PT;
        block0 = PT; encdec0 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        ord = 0;
        for (int k = 0; k < 4; k++) begin
            wait_sig(4, "t4_grant", g);
            who = grant1 ? 1 : 0;
            ord = (ord << 1) | who;
        end
        @(posedge aes_clk); #1 req0 = 1'b0; req1 = 1'b0;
        wait_sig(6, "t4_idle", d);
        chk("t4_order", ord, 4'b0101);
        chk("t4_results", {result0, result1}, {CT256, CT128});

        // Core not ready in IDLE: no grant
        @(posedge aes_clk); #1;
        stall = 1'b1; req0 = 1'b1;
        g0 = n_grant;
        repeat (6) @(negedge aes_clk);
        chk("t5_nogrant", n_grant - g0, 0);
        @(posedge aes_clk); #1 stall = 1'b0;
        wait_sig(0, "t5_grant", g);
        @(posedge aes_clk); #1 req0 = 1'b0;
        wait_sig(2, "t5_done", d);
        chk("t5_result", result0, CT256);

        // Reset during BLK_WAIT of a cache-hit op
        @(posedge aes_clk); #1 req0 = 1'b1;
        wait_sig(0, "t6_grant", g);
        @(posedge aes_clk); #1 req0 = 1'b0;
        wait_sig(5, "t6_next", d);
        d0 = n_done0;
        repeat (2) @(negedge aes_clk);
        @(posedge aes_clk); #1 aes_rst = 1'b1;
        @(posedge aes_clk); #1 aes_rst = 1'b0;
        @(negedge aes_clk);
        check_all_zero("t6_after_rst");
        repeat (10) @(negedge aes_clk);
        chk("t6_no_done", n_done0 - d0, 0);
        @(posedge aes_clk); #1 req0 = 1'b1;
        wait_sig(0, "t6_regrant", g);
        i0 = n_init;
        @(posedge aes_clk); #1 req0 = 1'b0;
        wait_sig(2, "t6_done", d);
        chk("t6_reinit", n_init - i0, 1);
        chk("t6_result", result0, CT256);
        chk("t6_latency", d - g, 12);

        repeat (3) @(negedge aes_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_core_arb.md
AES_CORE_ARB -- requirements
Module: aes_core_arb

Interface
REQ-001 SHALL have parameter KEY_CACHE_EN, default 1: when 1, key expansion is skipped if the latched key matches the key already expanded in the core.
REQ-002 SHALL have port aes_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port aes_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports req0/req1, input, 1 bit each: requester n asks for one block operation; level-sensitive.
REQ-005 SHALL have ports key0/key1, input, 256 bits each: requester key. Keys shorter than 256 bits are left-aligned in [255:128].
REQ-006 SHALL have ports keylen0/keylen1, input, 1 bit each: 1 = 256-bit key, 0 = 128-bit key.
REQ-007 SHALL have ports encdec0/encdec1, input, 1 bit each: 1 = encrypt, 0 = decrypt.
REQ-008 SHALL have ports block0/block1, input, 128 bits each: requester data block.
REQ-009 SHALL have ports grant0/grant1, output, 1 bit each: one-cycle pulse when the command of requester n is latched.
REQ-010 SHALL have ports done0/done1, output, 1 bit each: one-cycle pulse when result_n is valid.
REQ-011 SHALL have ports result0/result1, output, 128 bits each: result of the last completed operation of requester n; held until the next done_n.
REQ-012 SHALL have ports core_init and core_next, output, 1 bit each: one-cycle pulses to the shared aes_core.
REQ-013 SHALL have ports core_encdec (1 bit), core_keylen (1 bit), core_key (256 bits) and core_block (128 bits), all outputs: driven from the latched command registers.
REQ-014 SHALL have ports core_ready (1 bit) and core_result (128 bits), both inputs, from aes_core.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement states IDLE, KEY_INIT, KEY_WAIT, BLK_START, BLK_WAIT and DONE.
REQ-017 IDLE: if any req is high and core_ready=1, SHALL select a winner, latch the winner's key, keylen, encdec and block, pulse the winner's grant that cycle, and go to KEY_INIT or BLK_START (REQ-020).
REQ-018 Arbitration SHALL be round-robin. A lone requester wins. If both request, the requester other than last_winner wins. last_winner updates on every grant.
REQ-019 Only one grant SHALL be asserted in any cycle; grant SHALL never be asserted outside IDLE.
REQ-020 After a grant, the FSM SHALL go to BLK_START if KEY_CACHE_EN=1 and key_valid=1 and the latched key and keylen equal the cached key and keylen. Otherwise it SHALL go to KEY_INIT.
REQ-021 KEY_INIT: SHALL pulse core_init for exactly 1 cycle, then go to KEY_WAIT.
REQ-022 KEY_WAIT: SHALL ignore core_ready in the first cycle after entry. It SHALL then remain until core_ready=1, after which it SHALL update the cached key and keylen, set key_valid, and go to BLK_START.
REQ-023 BLK_START: SHALL pulse core_next for exactly 1 cycle, then go to BLK_WAIT.
REQ-024 BLK_WAIT: same wait rule as KEY_WAIT. On core_ready=1 it SHALL capture core_result into result_n of the owning requester and go to DONE.
REQ-025 DONE: SHALL pulse done_n of the owning requester for 1 cycle, then return to IDLE.
REQ-026 With a cache hit, latency from grant to done SHALL be (core block latency + 3) cycles.
REQ-027 core_key, core_keylen, core_encdec and core_block SHALL stay stable from the grant until the return to IDLE.
REQ-028 A requester that holds req high after its grant SHALL be treated as issuing a new request; it is eligible again in the next IDLE cycle.
REQ-029 Changes on req, key, block or encdec of either requester after its grant SHALL NOT affect the operation in flight.
REQ-030 In IDLE with core_ready=0, the FSM SHALL stay in IDLE and issue no grant.
REQ-031 core_init and core_next SHALL never be high in the same cycle.

Reset
REQ-032 When aes_rst=1 at a clock edge, the FSM SHALL go to IDLE and key_valid SHALL clear.
REQ-033 On reset, last_winner SHALL be 1, so req0 wins the first tie.
REQ-034 On reset, all outputs SHALL be 0: grant, done, result0/1, core_init, core_next, core_key, core_block, core_keylen, core_encdec and busy.
REQ-035 A reset during KEY_WAIT or BLK_WAIT SHALL abort the operation with no done pulse, and the next grant SHALL re-expand the key.

Verification
REQ-036 Single op: req0 with the FIPS-197 C.3 256-bit key 000102..1f, block 00112233445566778899aabbccddeeff, encdec=1 -> one grant0, one core_init, one core_next, done0 with result0=8ea2b7ca516745bfeafc49904b496089.
REQ-037 Key cache: a second req0 with the same key and a different block -> no core_init, done0 arrives exactly (block latency + 3) cycles after grant0.
REQ-038 Contention: req0 and req1 held high continuously -> grants alternate 0,1,0,1; each done matches its own requester's vectors.
REQ-039 Key change: req1 with a 128-bit key (keylen1=0) right after req0's 256-bit op -> core_init is reissued and the result matches FIPS-197 C.1 (69c4e0d86a7b0430d8cdb78070b4c55a).
REQ-040 Reset mid-op: aes_rst=1 for 1 cycle during BLK_WAIT -> no done pulse, all outputs 0, and the next request issues core_init.
